posit_accum_slot_sched_es3: RTL and testbench

- Time-multiplexes one ES3 raw posit accumulator pipeline among LAT independent accumulation contexts ("slots").
- The accumulator feedback loop is LAT registers deep, so each slot owns one fixed phase of a free-running counter.
- The scheduler accepts tagged elements from a single stream port and issues each element in its slot's phase.
- It returns each finished vector sum, then self-clears the slot by issuing the negated sum, so no accumulator reset is needed between vectors.

---
 rtl/posit_accum_slot_sched_es3.sv | 155 +++++++++++++++
 tb/tb_posit_accum_slot_sched_es3.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_slot_sched_es3.sv
// Slot scheduler that time-multiplexes one ES3 posit accumulator loop among LAT contexts.
// Optional POSIT_ACCUM_SCHED_TRUNC_STICKY_EN: per-slot sticky truncation covering the whole vector.
module posit_accum_slot_sched_es3 #(
    parameter int unsigned W   = 264,
    parameter int unsigned LAT = 16,
    parameter int unsigned CW  = 4,
    parameter int unsigned NW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_ctx,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    output logic [W-1:0]   acc_in1,
    output logic           acc_start,
    input  logic [W-1:0]   acc_result,
    input  logic           acc_truncated,
    output logic           out_valid,
    output logic [CW-1:0]  out_ctx,
    output logic [W-1:0]   out_data,
    output logic           out_truncated,
    output logic [NW-1:0]  out_count,
    output logic [LAT-1:0] slot_busy,
    output logic [LAT-1:0] slot_dead
);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDead} slot_state_e;

    localparam logic [W-1:0] SIGN_FLIP = {1'b1, {(W-1){1'b0}}};

    logic [CW-1:0] ph;
    slot_state_e   state_q [LAT];
    logic [NW-1:0] count_q [LAT];
    slot_state_e   cur;
    slot_state_e   state_d;
    logic [NW-1:0] count_d;
    logic          accept;
    logic          fire;
    logic          trunc_now;

`ifdef POSIT_ACCUM_SCHED_TRUNC_STICKY_EN
    logic sticky_q [LAT];
    logic sticky_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= '0;
        end else if (ph == CW'(LAT - 1)) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    always_comb begin
        cur       = state_q[ph];
        state_d   = cur;
        count_d   = count_q[ph];
        acc_in1   = '0;
        acc_start = 1'b0;
        fire      = 1'b0;
        in_ready  = (in_ctx == ph) && (int'(in_ctx) < int'(LAT))
                    && ((cur == StIdle) || (cur == StAccum));
        accept    = in_valid && in_ready;
        case (cur)
            StIdle, StAccum: begin
                if (accept) begin
                    acc_in1   = in_data;
                    acc_start = 1'b1;
                    state_d   = in_last ? StDrain : StAccum;
                    if (cur == StIdle) begin
                        count_d = NW'(1);
                    end else if (count_q[ph] != '1) begin
                        count_d = count_q[ph] + NW'(1);
                    end
                end
            end
            StDrain: begin
                fire = 1'b1;
                // An inf sum cannot be cancelled, so the slot is retired instead.
                if (!acc_result[1]) begin
                    acc_in1   = acc_result ^ SIGN_FLIP;
                    acc_start = 1'b1;
                    state_d   = StIdle;
                end else begin
                    state_d = StDead;
                end
            end
            default: ;
        endcase
    end

`ifdef POSIT_ACCUM_SCHED_TRUNC_STICKY_EN
    always_comb begin
        trunc_now = sticky_q[ph] | acc_truncated;
        sticky_d  = sticky_q[ph];
        if (cur == StAccum) begin
            sticky_d = sticky_q[ph] | acc_truncated;
        end else if (cur == StDrain) begin
            sticky_d = 1'b0;
        end
    end
`else
    always_comb begin
        trunc_now = acc_truncated;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(LAT); s++) begin
                state_q[s] <= StIdle;
                count_q[s] <= '0;
`ifdef POSIT_ACCUM_SCHED_TRUNC_STICKY_EN
                sticky_q[s] <= 1'b0;
`endif
            end
        end else begin
            state_q[ph] <= state_d;
            count_q[ph] <= count_d;
`ifdef POSIT_ACCUM_SCHED_TRUNC_STICKY_EN
            sticky_q[ph] <= sticky_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_ctx       <= '0;
            out_data      <= '0;
            out_truncated <= 1'b0;
            out_count     <= '0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_ctx       <= ph;
                out_data      <= acc_result;
                out_truncated <= trunc_now;
                out_count     <= count_q[ph];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < int'(LAT); s++) begin
            slot_busy[s] = (state_q[s] != StIdle);
            slot_dead[s] = (state_q[s] == StDead);
        end
    end

endmodule

// File: tb/tb_posit_accum_slot_sched_es3.sv
// Directed bench for posit_accum_slot_sched_es3 with a behavioural LAT-deep accumulator loop.
module tb_posit_accum_slot_sched_es3;

    localparam int W   = 264;
    localparam int LAT = 16;
    localparam int CW  = 4;
    localparam int NW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [CW-1:0]  in_ctx;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic [W-1:0]   acc_in1;
    logic           acc_start;
    logic [W-1:0]   acc_result;
    logic           acc_truncated;
    logic           out_valid;
    logic [CW-1:0]  out_ctx;
    logic [W-1:0]   out_data;
    logic           out_truncated;
    logic [NW-1:0]  out_count;
    logic [LAT-1:0] slot_busy;
    logic [LAT-1:0] slot_dead;

    posit_accum_slot_sched_es3 #(.W(W), .LAT(LAT), .CW(CW), .NW(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctx(in_ctx),
        .in_data(in_data), .in_last(in_last),
        .acc_in1(acc_in1), .acc_start(acc_start),
        .acc_result(acc_result), .acc_truncated(acc_truncated),
        .out_valid(out_valid), .out_ctx(out_ctx), .out_data(out_data),
        .out_truncated(out_truncated), .out_count(out_count),
        .slot_busy(slot_busy), .slot_dead(slot_dead)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic s, input logic [8:0] sc, input logic [7:0] f8,
                                        input logic inf, input logic zero);
        logic [W-1:0] r;
        r          = '0;
        r[263]     = s;
        r[262:254] = sc;
        r[253:246] = f8;
        r[1]       = inf;
        r[0]       = zero;
        return r;
    endfunction

    // Value scaled by 256; adequate for the small exact values used here.
    function automatic int dec(input logic [W-1:0] v);
        int sc;
        int m;
        int q;
        if (v[0]) return 0;
        sc = int'($signed(v[262:254]));
        m  = 256 + int'(v[253:246]);
        q  = (sc >= 0) ? (m << sc) : (m >>> (-sc));
        return v[263] ? -q : q;
    endfunction

    function automatic logic [W-1:0] enc(input int q);
        int          a;
        int          p;
        logic [31:0] tmp;
        logic [W-1:0] r;
        if (q == 0) return mk(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        a = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 31; i++) if (a[i]) p = i;
        tmp = a;
        tmp = tmp << (32 - p);
        r = mk(q < 0, 9'(p - 8), 8'd0, 1'b0, 1'b0);
        r[253:222] = tmp;
        return r;
    endfunction

    function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic st);
        if (a[1] || (st && b[1])) return mk(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        if (!st) return a;
        return enc(dec(a) + dec(b));
    endfunction

    // Accumulator loop model: issue at cycle t is visible on acc_result at t+LAT.
    logic [W-1:0] sr [LAT];
    assign acc_result = sr[LAT-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sr[i] <= mk(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        end else begin
            for (int i = LAT - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= acc_add(sr[LAT-1], acc_in1, acc_start);
        end
    end

    int cyc = 0;
    int ph_tb;
    always @(posedge clk or posedge rst) begin
        if (rst) ph_tb <= 0;
        else     ph_tb <= (ph_tb + 1) % LAT;
    end
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0]  ctx;
        logic [W-1:0]   data;
        logic           trunc;
        logic [NW-1:0]  cnt;
        logic [LAT-1:0] busy;
        logic [LAT-1:0] dead;
        int             cyc;
    } out_rec_t;

    out_rec_t outq [$];

    always @(negedge clk) begin
        out_rec_t r;
        if (out_valid) begin
            r.ctx   = out_ctx;
            r.data  = out_data;
            r.trunc = out_truncated;
            r.cnt   = out_count;
            r.busy  = slot_busy;
            r.dead  = slot_dead;
            r.cyc   = cyc;
            outq.push_back(r);
        end
    end

    task automatic send(input int ctx, input logic [W-1:0] d, input logic last,
                        output int waited, output int acc_cyc);
        @(negedge clk);
        in_valid = 1'b1;
        in_ctx   = CW'(ctx);
        in_data  = d;
        in_last  = last;
        waited   = 0;
        acc_cyc  = 0;
        for (;;) begin
            #1;
            if (in_ready) break;
            waited++;
            if (waited >= 40) break;
            @(negedge clk);
        end
        if (!in_ready) chk("send_ready", W'(in_ready), W'(1));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output out_rec_t r);
        for (int n = 0; n < 200 && outq.size() == 0; n++) @(negedge clk);
        chk("out_arrived", W'(outq.size() != 0), W'(1));
        if (outq.size() != 0) r = outq.pop_front();
        else r = '{default: '0};
    endtask

    logic [W-1:0] ONE, TWO, THREE, NEG_ONE, HALF, NEG_HALF, INF_V;
    out_rec_t r;
    int w, t;
    int ready_seen;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ONE      = mk(1'b0, 9'd0,   8'h00, 1'b0, 1'b0);
        TWO      = mk(1'b0, 9'd1,   8'h00, 1'b0, 1'b0);
        THREE    = mk(1'b0, 9'd1,   8'h80, 1'b0, 1'b0);
        NEG_ONE  = mk(1'b1, 9'd0,   8'h00, 1'b0, 1'b0);
        HALF     = mk(1'b0, 9'h1FF, 8'h00, 1'b0, 1'b0);
        NEG_HALF = mk(1'b1, 9'h1FF, 8'h00, 1'b0, 1'b0);
        INF_V    = mk(1'b0, 9'd0,   8'h00, 1'b1, 1'b0);

        rst = 1'b1; in_valid = 1'b0; in_ctx = '0; in_data = '0; in_last = 1'b0;
        acc_truncated = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_out_count", W'(out_count), W'(0));
        chk("rst_slot_busy", W'(slot_busy), W'(0));
        chk("rst_acc_start", W'(acc_start), W'(0));
        rst = 1'b0;

        // ctx3: 1+1+1
        send(3, ONE, 1'b0, w, t);
        send(3, ONE, 1'b0, w, t);
        send(3, ONE, 1'b1, w, t);
        wait_out(r);
        chk("v1_ctx", W'(r.ctx), W'(3));
        chk("v1_data", r.data, THREE);
        chk("v1_count", W'(r.cnt), W'(3));
        chk("v1_trunc", W'(r.trunc), W'(0));
        chk("v1_latency", W'(r.cyc - t), W'(LAT + 1));
        chk("v1_busy3", W'(r.busy[3]), W'(0));

        // ctx3 again: exact 2.0 shows the slot was cancelled to zero
        acc_truncated = 1'b1;
        send(3, TWO, 1'b1, w, t);
        wait_out(r);
        acc_truncated = 1'b0;
        chk("v2_data", r.data, TWO);
        chk("v2_count", W'(r.cnt), W'(1));
        chk("v2_trunc", W'(r.trunc), W'(1));
        @(negedge clk); @(negedge clk);
        chk("v2_hold", out_data, TWO);
        chk("v2_pulse", W'(out_valid), W'(0));

        // interleaved ctx0 and ctx5
        send(0, ONE, 1'b0, w, t);
        send(5, NEG_ONE, 1'b0, w, t);
        send(0, ONE, 1'b1, w, t);
        send(5, HALF, 1'b1, w, t);
        wait_out(r);
        chk("i0_ctx", W'(r.ctx), W'(0));
        chk("i0_data", r.data, TWO);
        chk("i0_count", W'(r.cnt), W'(2));
        wait_out(r);
        chk("i5_ctx", W'(r.ctx), W'(5));
        chk("i5_data", r.data, NEG_HALF);
        chk("i5_count", W'(r.cnt), W'(2));

        // phase alignment: request ctx2 starting at ph=7
        for (int n = 0; n < 40 && ph_tb != 6; n++) @(negedge clk);
        send(2, ONE, 1'b1, w, t);
        chk("ph_wait11", W'(w), W'(11));
        send(2, TWO, 1'b1, w, t);
        chk("drain_refuse_wait31", W'(w), W'(31));
        wait_out(r);
        chk("p_first", r.data, ONE);
        wait_out(r);
        chk("p_second", r.data, TWO);

        // inf into ctx4 kills the slot
        send(4, INF_V, 1'b1, w, t);
        wait_out(r);
        chk("inf_bit", W'(r.data[1]), W'(1));
        chk("inf_dead4", W'(r.dead[4]), W'(1));
        @(negedge clk);
        in_valid = 1'b1; in_ctx = CW'(4); in_data = ONE; in_last = 1'b1;
        ready_seen = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (in_ready) ready_seen++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("dead_never_ready", W'(ready_seen), W'(0));
        chk("dead_busy4", W'(slot_busy[4]), W'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_clears_dead", W'(slot_dead), W'(0));
        rst = 1'b0;

        // rst mid-vector on ctx1
        send(1, ONE, 1'b0, w, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_data", out_data, W'(0));
        chk("mid_rst_count", W'(out_count), W'(0));
        chk("mid_rst_busy", W'(slot_busy), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_out", W'(outq.size()), W'(0));
        send(1, ONE, 1'b1, w, t);
        wait_out(r);
        chk("post_rst_ctx", W'(r.ctx), W'(1));
        chk("post_rst_data", r.data, ONE);
        chk("post_rst_count", W'(r.cnt), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
